int_to_float_pipe: RTL and testbench

Parametrised, pipelined integer-to-floating-point converter for the attention-layer datapath. It converts a signed or unsigned `IN_WIDTH`-bit integer into an IEEE-style float with `EXP_W` exponent bits and `MAN_W` mantissa bits. Rounding is selectable per transaction, and the block reports overflow and inexact flags. It sits between the integer accumulators and the fp16 softmax/scaling stages, using a valid/ready handshake so downstream stalls propagate without data loss.

---
 rtl/fp_cvt_pkg.sv | 25 ++
 rtl/lzc_param.sv | 21 ++
 rtl/int_to_float_pipe.sv | 142 ++++++++++++++
 tb/tb_int_to_float_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cvt_pkg.sv
// Shared constants and helpers for the integer-to-float converter.
// Rounding-mode encoding, default field widths, bias and shift-width helpers.
package fp_cvt_pkg;

  localparam int DEF_IN_WIDTH = 16;
  localparam int DEF_EXP_W    = 5;
  localparam int DEF_MAN_W    = 10;
  localparam int SIGN_W       = 1;

  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int shamt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lzc_param.sv
// Parametrised leading-zero counter; an all-zero input yields W.
// Ports: a (W-bit operand), cnt (leading zero count, $clog2(W)+1 bits).
module lzc_param
  import fp_cvt_pkg::*;
#(
  parameter int W = DEF_IN_WIDTH
) (
  input  logic [W-1:0]          a,
  output logic [shamt_w(W)-1:0] cnt
);

  localparam int CW = shamt_w(W);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/int_to_float_pipe.sv
// Three-stage int-to-float converter with valid/ready flow control.
// Ports: clk, reset, in_* beat (data/signed/rtz), out_* result + flags.
module int_to_float_pipe
  import fp_cvt_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int EXP_W    = DEF_EXP_W,
  parameter int MAN_W    = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_signed,
  input  logic                   in_rtz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic                   out_overflow,
  output logic                   out_inexact
);

  localparam int LZW   = shamt_w(IN_WIDTH);
  localparam int FW    = IN_WIDTH - 1;
  localparam int EXT_W = imax(FW, MAN_W + 3);
  localparam int SH    = EXT_W - FW;
  localparam int BIAS  = bias(EXP_W);
  localparam int MAXE  = (1 << EXP_W) - 1;
  localparam logic [EXP_W-1:0] MAXF_E = EXP_W'(MAXE - 1);

  logic en1, en2, en3;
  logic v1, v2, v3;

  logic                s1_sign, s1_rtz;
  logic [IN_WIDTH-1:0] s1_mag;

  logic                s2_sign, s2_rtz, s2_zero;
  logic [FW-1:0]       s2_frac;
  logic [LZW-1:0]      s2_exp;

  // Each stage may load when empty or when its contents move on.
  assign en3      = !v3 | out_ready;
  assign en2      = !v2 | en3;
  assign en1      = !v1 | en2;
  assign in_ready = en1;
  assign out_valid = v3;

  logic                sign_c;
  logic [IN_WIDTH-1:0] mag_c;

  assign sign_c = in_signed & in_data[IN_WIDTH-1];
  assign mag_c  = sign_c ? (~in_data + IN_WIDTH'(1)) : in_data;

  logic [LZW-1:0]      lz;
  logic [IN_WIDTH-1:0] norm_c;
  logic [LZW-1:0]      e_c;

  lzc_param #(.W(IN_WIDTH)) u_lzc (
    .a   (s1_mag),
    .cnt (lz)
  );

  assign norm_c = s1_mag << lz;
  assign e_c    = LZW'(IN_WIDTH - 1) - lz;

  logic [EXT_W-1:0]     ext;
  logic [MAN_W-1:0]     mant;
  logic                 g, r, st, inx;
  logic                 inc, clip, ovf;
  logic [MAN_W:0]       msum;
  logic [31:0]          bexp;
  logic [EXP_W+MAN_W:0] res;

  always_comb begin
    ext  = EXT_W'(s2_frac) << SH;
    mant = ext[EXT_W-1 -: MAN_W];
    g    = ext[EXT_W-1-MAN_W];
    r    = ext[EXT_W-2-MAN_W];
    st   = |ext[EXT_W-3-MAN_W:0];
    inx  = g | r | st;
    inc  = !s2_rtz & g & (r | st | mant[0]);
    msum = {1'b0, mant} + (MAN_W+1)'(inc);
    bexp = 32'(s2_exp) + 32'(msum[MAN_W]) + 32'(BIAS);
    // A truncated value still above max-finite counts as overflow.
    clip = s2_rtz & (&mant) & inx & (bexp == 32'(MAXE - 1));
    ovf  = (bexp >= 32'(MAXE)) | clip;
    if (ovf) begin
      if (s2_rtz) res = {s2_sign, MAXF_E, {MAN_W{1'b1}}};
      else        res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      res = {s2_sign, bexp[EXP_W-1:0], msum[MAN_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      s1_sign      <= 1'b0;
      s1_rtz       <= 1'b0;
      s1_mag       <= '0;
      s2_sign      <= 1'b0;
      s2_rtz       <= 1'b0;
      s2_zero      <= 1'b1;
      s2_frac      <= '0;
      s2_exp       <= '0;
      out_data     <= '0;
      out_overflow <= 1'b0;
      out_inexact  <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en1 & in_valid) begin
        s1_sign <= sign_c;
        s1_rtz  <= in_rtz;
        s1_mag  <= mag_c;
      end
      if (en2) v2 <= v1;
      if (en2 & v1) begin
        s2_sign <= s1_sign;
        s2_rtz  <= s1_rtz;
        s2_zero <= !norm_c[IN_WIDTH-1];
        s2_frac <= norm_c[FW-1:0];
        s2_exp  <= e_c;
      end
      if (en3) v3 <= v2;
      if (en3 & v2) begin
        if (s2_zero) begin
          out_data     <= '0;
          out_overflow <= 1'b0;
          out_inexact  <= 1'b0;
        end else begin
          out_data     <= res;
          out_overflow <= ovf;
          out_inexact  <= inx | ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Self-checking bench for int_to_float_pipe (16-bit in, fp16 out).
// Table vectors, streaming latency, random back-pressure and reset.
module tb_int_to_float_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_signed = 1'b0;
  logic        in_rtz = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_overflow;
  logic        out_inexact;

  always #5 clk = ~clk;

  int_to_float_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_signed    (in_signed),
    .in_rtz       (in_rtz),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .out_inexact  (out_inexact)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] res;
    logic        ovf;
    logic        inx;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic        sgn;
    logic        rtz;
    logic [15:0] res;
    logic        ovf;
    logic        inx;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rmode = 0;
  int   n_acc = 0;
  int   n_out = 0;
  exp_t cur_exp;
  exp_t sb[$];
  int   out_cyc[$];

  logic        have_prev = 1'b0;
  logic [17:0] prev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic exp_t model(logic [15:0] d, logic s, logic rtz);
    exp_t x;
    int   mag, e, q, rem, half, sh;
    logic sign;
    x.din = d;
    x.res = '0;
    x.ovf = 1'b0;
    x.inx = 1'b0;
    sign = s & d[15];
    mag = sign ? 65536 - int'(d) : int'(d);
    if (mag == 0) return x;
    e = 0;
    for (int i = 0; i < 17; i++) if (mag >= (1 << i)) e = i;
    rem = 0;
    if (e > 10) begin
      sh = e - 10;
      q = mag >> sh;
      rem = mag & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (!rtz && (rem > half || (rem == half && q % 2 == 1))) q++;
    end else begin
      q = mag << (10 - e);
    end
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    x.inx = (rem != 0);
    if (rtz ? (mag > 65504) : (e + 15 >= 31)) begin
      x.ovf = 1'b1;
      x.inx = 1'b1;
      x.res = rtz ? {sign, 15'h7BFF} : {sign, 15'h7C00};
    end else begin
      x.res = {sign, 5'(e + 15), 10'(q - 1024)};
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      have_prev = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !(sb.size() == 3 && !out_ready)) begin
        errors++;
        $display("FAIL in_ready: got %b, want %b (occ %0d ordy %b)",
                 in_ready, !(sb.size() == 3 && !out_ready),
                 sb.size(), out_ready);
      end
      if (have_prev) begin
        checks++;
        if ({out_data, out_overflow, out_inexact} !== prev) begin
          errors++;
          $display("FAIL stall_hold: got %h, want %h",
                   {out_data, out_overflow, out_inexact}, prev);
        end
      end
      have_prev = out_valid && !out_ready;
      prev = {out_data, out_overflow, out_inexact};
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_output: got %h, want none", out_data);
        end else begin
          exp_t x;
          x = sb.pop_front();
          if ({out_data, out_overflow, out_inexact} !==
              {x.res, x.ovf, x.inx}) begin
            errors++;
            $display("FAIL result in=%h: got %h ovf=%b inx=%b, want %h ovf=%b inx=%b",
                     x.din, out_data, out_overflow, out_inexact,
                     x.res, x.ovf, x.inx);
          end
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        sb.push_back(cur_exp);
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic s,
                      input logic r, input exp_t e, output int acc);
    int   n;
    logic got;
    n = 0;
    got = 1'b0;
    acc = -1;
    in_data = d;
    in_signed = s;
    in_rtz = r;
    cur_exp = e;
    in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got no in_ready, want accept in=%h", d);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if ({out_valid, out_data, out_overflow, out_inexact, in_ready} !==
        {1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h o=%b i=%b rdy=%b, want 0 0000 0 0 1",
               tag, out_valid, out_data, out_overflow, out_inexact, in_ready);
    end
  endtask

  vec_t vt[$];

  initial begin
    int   acc, c0, n;
    logic [15:0] d;
    logic s, r;

    vt.push_back('{16'd0,     1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    vt.push_back('{16'd1,     1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0});
    vt.push_back('{16'd2049,  1'b0, 1'b0, 16'h6800, 1'b0, 1'b1});
    vt.push_back('{16'd2051,  1'b0, 1'b0, 16'h6802, 1'b0, 1'b1});
    vt.push_back('{16'hFFFF,  1'b1, 1'b0, 16'hBC00, 1'b0, 1'b0});
    vt.push_back('{16'h8000,  1'b1, 1'b0, 16'hF800, 1'b0, 1'b0});
    vt.push_back('{16'hFFFF,  1'b0, 1'b0, 16'h7C00, 1'b1, 1'b1});
    vt.push_back('{16'hFFFF,  1'b0, 1'b1, 16'h7BFF, 1'b1, 1'b1});
    vt.push_back('{16'd2049,  1'b0, 1'b1, 16'h6800, 1'b0, 1'b1});
    vt.push_back('{16'd2051,  1'b0, 1'b1, 16'h6801, 1'b0, 1'b1});
    vt.push_back('{16'h7FFF,  1'b1, 1'b0, 16'h7800, 1'b0, 1'b1});
    vt.push_back('{16'd65504, 1'b0, 1'b0, 16'h7BFF, 1'b0, 1'b0});
    vt.push_back('{16'd65520, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b1});
    vt.push_back('{16'hFFEF,  1'b0, 1'b0, 16'h7BFF, 1'b0, 1'b1});
    vt.push_back('{16'hFFFE,  1'b1, 1'b0, 16'hC000, 1'b0, 1'b0});
    vt.push_back('{16'd0,     1'b1, 1'b1, 16'h0000, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      exp_t x;
      x.din = vt[i].din;
      x.res = vt[i].res;
      x.ovf = vt[i].ovf;
      x.inx = vt[i].inx;
      send(vt[i].din, vt[i].sgn, vt[i].rtz, x, acc);
    end
    drain();

    out_cyc.delete();
    c0 = -1;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      send(d, s, r, model(d, s, r), acc);
      if (i == 0) c0 = acc;
    end
    n = 0;
    while (out_cyc.size() < 8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_cyc.size() < 8 || out_cyc[0] != c0 + 3) begin
      errors++;
      $display("FAIL stream_latency: got %0d outs first@%0d, want 8 first@%0d",
               out_cyc.size(), (out_cyc.size() > 0) ? out_cyc[0] : -1, c0 + 3);
    end else begin
      checks++;
      if (out_cyc[7] != out_cyc[0] + 7) begin
        errors++;
        $display("FAIL stream_gaps: got last@%0d, want %0d",
                 out_cyc[7], out_cyc[0] + 7);
      end
    end
    drain();

    rmode = 2;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 7) == 0) d = 16'($urandom_range(0, 4)) | 16'hFFF0;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      send(d, s, r, model(d, s, r), acc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rmode = 0;
    drain();
    checks++;
    if (n_acc != n_out) begin
      errors++;
      $display("FAIL beat_count: got %0d out, want %0d", n_out, n_acc);
    end

    rmode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d = 16'(100 + i);
      send(d, 1'b0, 1'b0, model(d, 1'b0, 1'b0), acc);
    end
    @(negedge clk);
    checks++;
    if (!(out_valid && !in_ready)) begin
      errors++;
      $display("FAIL full_stall: got v=%b rdy=%b, want v=1 rdy=0",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rmode = 0;
    @(negedge clk);
    check_idle("mid_reset");
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_t x;
      x.din = vt[i + 4].din;
      x.res = vt[i + 4].res;
      x.ovf = vt[i + 4].ovf;
      x.inx = vt[i + 4].inx;
      send(vt[i + 4].din, vt[i + 4].sgn, vt[i + 4].rtz, x, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
